// File: rtl/fpu_pkg.sv
// Shared FPU definitions: FSM states, op encoding, flag bit positions and IEEE field helpers.
package fpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_OUT
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int unsigned FLAGS_W        = 4;
    localparam int unsigned FLAG_INVALID   = 3;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_INEXACT   = 0;

    localparam int unsigned MAX_WORD_W = 128;

    function automatic int unsigned exp_max(input int unsigned exp_w);
        return (32'd1 << exp_w) - 32'd1;
    endfunction

    function automatic int unsigned bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

    // Canonical quiet NaN: positive, all-ones exponent, only the fraction MSB set.
    function automatic logic [MAX_WORD_W-1:0] qnan(input int unsigned exp_w, input int unsigned mant_w);
        logic [MAX_WORD_W-1:0] q;
        q = ((MAX_WORD_W'(1) << exp_w) - MAX_WORD_W'(1)) << mant_w;
        q = q | (MAX_WORD_W'(1) << (mant_w - 32'd1));
        return q;
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; count_c equals WIDTH for an all-zero input.
module fpu_lzc
    import fpu_pkg::*;
#(
    parameter  int unsigned WIDTH = 28,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count_c
);
    logic found;

    always_comb begin
        count_c = '0;
        found   = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (value[i]) begin
                    found = 1'b1;
                end else begin
                    count_c = count_c + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/fpu_addsub.sv
// IEEE-754 add/subtract lane: multi-cycle unpack/align/add/normalise/round, RNE, flush-to-zero.
module fpu_addsub
    import fpu_pkg::*;
#(
    parameter  int unsigned EXP_W  = 8,
    parameter  int unsigned MANT_W = 23,
    localparam int unsigned W      = 1 + EXP_W + MANT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    input  logic               op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       result,
    output logic [FLAGS_W-1:0] flags
);
    localparam int unsigned DW     = MANT_W + 4;
    localparam int unsigned SW     = MANT_W + 5;
    localparam int unsigned EW     = EXP_W + 2;
    localparam int unsigned MRW    = MANT_W + 2;
    localparam int unsigned MAX_SH = MANT_W + 3;
    localparam int unsigned SHW    = $clog2(DW);
    localparam int unsigned LZW    = $clog2(SW + 1);
    localparam int unsigned EMAX   = exp_max(EXP_W);
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic signed [EW-1:0] EMAX_S   = EW'(EMAX);
    localparam logic signed [EW-1:0] E_ZERO   = '0;
    localparam logic [W-1:0]         QNAN     = W'(qnan(EXP_W, MANT_W));

    state_t state, state_next;
    logic   accept;

    logic [W-1:0]          a_q, b_q;
    logic                  op_q;
    logic                  sign_a_q, sign_b_q;
    logic [EXP_W-1:0]      exp_a_q, exp_b_q;
    logic [MANT_W:0]       mant_a_q, mant_b_q;
    logic                  sign_q, sub_q;
    logic signed [EW-1:0]  exp_q;
    logic [DW-1:0]         mant_l_q, mant_s_q, mant_n_q;
    logic [SW-1:0]         sum_q;
    logic [W-1:0]          res_q;
    logic [FLAGS_W-1:0]    flg_q;

    assign accept = in_valid && in_ready;

    // Unpack and special-case detection
    logic [EXP_W-1:0]   ea, eb;
    logic [MANT_W-1:0]  fa, fb;
    logic               sa, sb;
    logic               a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    logic               special;
    logic [W-1:0]       spec_res;
    logic [FLAGS_W-1:0] spec_flg;

    always_comb begin
        ea       = a_q[W-2:MANT_W];
        eb       = b_q[W-2:MANT_W];
        fa       = a_q[MANT_W-1:0];
        fb       = b_q[MANT_W-1:0];
        sa       = a_q[W-1];
        sb       = b_q[W-1] ^ (op_q == OP_SUB);
        a_nan    = (ea == EXP_ONES) && (fa != '0);
        b_nan    = (eb == EXP_ONES) && (fb != '0);
        a_snan   = a_nan && !fa[MANT_W-1];
        b_snan   = b_nan && !fb[MANT_W-1];
        a_inf    = (ea == EXP_ONES) && (fa == '0);
        b_inf    = (eb == EXP_ONES) && (fb == '0);
        a_zero   = (ea == '0);
        b_zero   = (eb == '0);
        special  = 1'b1;
        spec_res = '0;
        spec_flg = '0;
        if (a_nan || b_nan) begin
            spec_res               = QNAN;
            spec_flg[FLAG_INVALID] = a_snan || b_snan;
        end else if (a_inf && b_inf && (sa != sb)) begin
            spec_res               = QNAN;
            spec_flg[FLAG_INVALID] = 1'b1;
        end else if (a_inf) begin
            spec_res = {sa, EXP_ONES, {MANT_W{1'b0}}};
        end else if (b_inf) begin
            spec_res = {sb, EXP_ONES, {MANT_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            spec_res = {sa && sb, {(W-1){1'b0}}};
        end else if (a_zero) begin
            spec_res = {sb, b_q[W-2:0]};
        end else if (b_zero) begin
            spec_res = a_q;
        end else begin
            special = 1'b0;
        end
    end

    // Align: larger magnitude first, smaller shifted right with sticky collection
    logic              a_big, s_l;
    logic [EXP_W-1:0]  e_l, e_s, exp_diff;
    logic [MANT_W:0]   m_l, m_s;
    logic [SHW-1:0]    shamt;
    logic [DW-1:0]     ext_s, shifted, lost_mask, aligned;

    always_comb begin
        a_big     = (exp_a_q > exp_b_q) || ((exp_a_q == exp_b_q) && (mant_a_q >= mant_b_q));
        s_l       = a_big ? sign_a_q : sign_b_q;
        e_l       = a_big ? exp_a_q  : exp_b_q;
        e_s       = a_big ? exp_b_q  : exp_a_q;
        m_l       = a_big ? mant_a_q : mant_b_q;
        m_s       = a_big ? mant_b_q : mant_a_q;
        exp_diff  = e_l - e_s;
        shamt     = (32'(exp_diff) > MAX_SH) ? SHW'(MAX_SH) : SHW'(exp_diff);
        ext_s     = {m_s, 3'b000};
        lost_mask = (DW'(1) << shamt) - DW'(1);
        shifted   = ext_s >> shamt;
        aligned   = {shifted[DW-1:1], shifted[0] | (|(ext_s & lost_mask))};
    end

    logic [SW-1:0] sum_c;
    assign sum_c = sub_q ? ({1'b0, mant_l_q} - {1'b0, mant_s_q})
                         : ({1'b0, mant_l_q} + {1'b0, mant_s_q});

    // Normalise: one-step right shift on carry, otherwise left shift by leading zeros
    logic [LZW-1:0]       lz, norm_sh;
    logic                 sum_zero;
    logic [DW-1:0]        mant_n;
    logic signed [EW-1:0] exp_n;

    fpu_lzc #(.WIDTH(SW)) u_lzc (
        .value   (sum_q),
        .count_c (lz)
    );

    always_comb begin
        sum_zero = (sum_q == '0);
        norm_sh  = lz - LZW'(1);
        if (sum_q[SW-1]) begin
            mant_n = {sum_q[SW-1:2], sum_q[1] | sum_q[0]};
            exp_n  = exp_q + EW'(1);
        end else begin
            mant_n = DW'(sum_q << norm_sh);
            exp_n  = exp_q - EW'(norm_sh);
        end
    end

    // Round to nearest even and apply exponent limits
    logic                 g, r, s, lsb, inc;
    logic [MRW-1:0]       m_r;
    logic [MANT_W-1:0]    frac_r;
    logic signed [EW-1:0] e_r;
    logic [W-1:0]         round_res;
    logic [FLAGS_W-1:0]   round_flg;

    always_comb begin
        lsb       = mant_n_q[3];
        g         = mant_n_q[2];
        r         = mant_n_q[1];
        s         = mant_n_q[0];
        inc       = g && (r || s || lsb);
        m_r       = {1'b0, mant_n_q[DW-1:3]} + MRW'(inc);
        frac_r    = MANT_W'(m_r >> m_r[MRW-1]);
        e_r       = exp_q + EW'(m_r[MRW-1]);
        round_flg = '0;
        round_flg[FLAG_INEXACT] = g || r || s;
        round_res = {sign_q, e_r[EXP_W-1:0], frac_r};
        if (e_r >= EMAX_S) begin
            round_res = {sign_q, EXP_ONES, {MANT_W{1'b0}}};
            round_flg[FLAG_OVERFLOW] = 1'b1;
            round_flg[FLAG_INEXACT]  = 1'b1;
        end else if (e_r <= E_ZERO) begin
            round_res = {sign_q, {(W-1){1'b0}}};
            round_flg[FLAG_UNDERFLOW] = 1'b1;
            round_flg[FLAG_INEXACT]   = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (accept) state_next = S_UNPACK;
            S_UNPACK: state_next = special ? S_OUT : S_ALIGN;
            S_ALIGN:  state_next = S_ADD;
            S_ADD:    state_next = S_NORM;
            S_NORM:   state_next = sum_zero ? S_OUT : S_ROUND;
            S_ROUND:  state_next = S_OUT;
            S_OUT:    if (out_valid && out_ready) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Handshake outputs; result is latched once on OUT entry and held until taken
    always_ff @(posedge clock) begin
        if (reset) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            in_ready <= (state_next == S_IDLE);
            if ((state == S_OUT) && !out_valid) begin
                out_valid <= 1'b1;
                result    <= res_q;
                flags     <= flg_q;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    a_q  <= a;
                    b_q  <= b;
                    op_q <= op;
                end
            end
            S_UNPACK: begin
                if (special) begin
                    res_q <= spec_res;
                    flg_q <= spec_flg;
                end else begin
                    sign_a_q <= sa;
                    sign_b_q <= sb;
                    exp_a_q  <= ea;
                    exp_b_q  <= eb;
                    mant_a_q <= {1'b1, fa};
                    mant_b_q <= {1'b1, fb};
                end
            end
            S_ALIGN: begin
                sign_q   <= s_l;
                sub_q    <= sign_a_q ^ sign_b_q;
                exp_q    <= EW'(e_l);
                mant_l_q <= {m_l, 3'b000};
                mant_s_q <= aligned;
            end
            S_ADD: sum_q <= sum_c;
            S_NORM: begin
                if (sum_zero) begin
                    res_q <= '0;
                    flg_q <= '0;
                end else begin
                    mant_n_q <= mant_n;
                    exp_q    <= exp_n;
                end
            end
            S_ROUND: begin
                res_q <= round_res;
                flg_q <= round_flg;
            end
            default: ;
        endcase
    end

endmodule
